// File: rtl/rx_path_pkg.sv
// rx_path_pkg: shared sizing helper, I/Q field offsets and decision polarity for the RX path.
package rx_path_pkg;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int i_lsb(input int sample_w);
    return sample_w;
  endfunction
  localparam int Q_LSB = 0;
  localparam logic NEG_DECISION = 1'b1;
endpackage

// File: rtl/rx_sym_fifo.sv
// rx_sym_fifo: synchronous FIFO with occupancy output; head reads as zero while empty.
module rx_sym_fifo import rx_path_pkg::*; #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 16,
  localparam int LW = clog2(DEPTH + 1),
  localparam int PW = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] level_q, level_d;
  logic do_push, do_pop;
  always_comb begin
    full = level_q == LW'(DEPTH);
    empty = level_q == '0;
    do_push = push && !full;
    do_pop = pop && !empty;
    wr_d = wr_q + PW'(do_push);
    rd_d = rd_q + PW'(do_pop);
    level_d = level_q + LW'(do_push) - LW'(do_pop);
    rdata = empty ? '0 : mem[rd_q];
    level = level_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      level_q <= level_d;
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_q] <= wdata;
endmodule

// File: rtl/rx_iq_slicer_fifo.sv
// rx_iq_slicer_fifo: integrate-and-dump I/Q slicer packing NSYM sign decisions per beat into an output FIFO.
module rx_iq_slicer_fifo import rx_path_pkg::*; #(
  parameter int SAMPLE_W = 12,
  parameter int SPS = 4,
  parameter int NSYM = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  input  logic [2*SAMPLE_W-1:0]              in_data,
  output logic                               in_ready,
  input  logic                               align,
  output logic                               out_valid,
  output logic [2*NSYM-1:0]                  out_data,
  input  logic                               out_ready,
  output logic [clog2(FIFO_DEPTH+1)-1:0]     fifo_level
);
  localparam int ACC_W = SAMPLE_W + clog2(SPS);
  localparam int SC_W = clog2(SPS) > 0 ? clog2(SPS) : 1;
  localparam int NC_W = clog2(NSYM) > 0 ? clog2(NSYM) : 1;
  logic [SC_W-1:0] samp_q, samp_d;
  logic [NC_W-1:0] sym_q, sym_d;
  logic signed [ACC_W-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d, sum_i, sum_q;
  logic [2*NSYM-1:0] pack_q, pack_d, beat;
  logic sym_end, word_end, accept, full, empty;
  always_comb begin
    sum_i = acc_i_q + ACC_W'($signed(in_data[i_lsb(SAMPLE_W) +: SAMPLE_W]));
    sum_q = acc_q_q + ACC_W'($signed(in_data[Q_LSB +: SAMPLE_W]));
    sym_end = samp_q == SC_W'(SPS - 1);
    word_end = sym_end && sym_q == NC_W'(NSYM - 1);
    in_ready = rst && !align && !(full && word_end);
    accept = in_valid && in_ready;
    beat = pack_q;
    beat[2*sym_q +: 2] = {sum_i[ACC_W-1] ? NEG_DECISION : !NEG_DECISION,
                          sum_q[ACC_W-1] ? NEG_DECISION : !NEG_DECISION};
    samp_d = samp_q;
    sym_d = sym_q;
    acc_i_d = acc_i_q;
    acc_q_d = acc_q_q;
    pack_d = pack_q;
    if (align) begin
      samp_d = '0;
      sym_d = '0;
      acc_i_d = '0;
      acc_q_d = '0;
      pack_d = '0;
    end else if (accept) begin
      samp_d = sym_end ? '0 : samp_q + 1'b1;
      acc_i_d = sym_end ? '0 : sum_i;
      acc_q_d = sym_end ? '0 : sum_q;
      if (sym_end) begin
        sym_d = word_end ? '0 : sym_q + 1'b1;
        pack_d = word_end ? '0 : beat;
      end
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      samp_q <= '0;
      sym_q <= '0;
      acc_i_q <= '0;
      acc_q_q <= '0;
      pack_q <= '0;
    end else begin
      samp_q <= samp_d;
      sym_q <= sym_d;
      acc_i_q <= acc_i_d;
      acc_q_q <= acc_q_d;
      pack_q <= pack_d;
    end
  // The completing symbol's decisions come straight from sum, not from pack_q.
  rx_sym_fifo #(.WIDTH(2*NSYM), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(accept && word_end),
    .wdata(beat),
    .pop(out_ready),
    .rdata(out_data),
    .full(full),
    .empty(empty),
    .level(fifo_level)
  );
  assign out_valid = !empty;
endmodule
